// File: rtl/cmt_stage.sv
// cmt_stage: commit register, counters, trap and watchdog halt; optional MMIO skip via CMT_MMIO_SKIP_EN
module cmt_stage #(
  parameter int          TIMEOUT     = 5000,
  parameter logic [6:0]  TRAP_OPCODE = 7'h6b,
  parameter logic [63:0] MMIO_TOP    = 64'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [63:0] wb_pc,
  input  logic [31:0] wb_inst,
  input  logic        wb_rd_wen,
  input  logic [4:0]  wb_rd_waddr,
  input  logic [63:0] wb_rd_wdata,
  input  logic [63:0] wb_a0,
  input  logic        wb_mem_access,
  input  logic [63:0] wb_mem_addr,
  output logic        cmt_valid,
  output logic [63:0] cmt_pc,
  output logic [31:0] cmt_inst,
  output logic        cmt_wen,
  output logic [7:0]  cmt_wdest,
  output logic [63:0] cmt_wdata,
  output logic        cmt_skip,
  output logic        trap_valid,
  output logic [7:0]  trap_code,
  output logic [63:0] trap_pc,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instr_cnt,
  output logic        halted
);
  typedef enum logic [1:0] {RUN, TRAPPED, TIMED_OUT} state_t;
  state_t state, state_nxt;
  logic [31:0] wd;
  logic accept, is_trap, expire, skip_d, wen_d;
`ifdef CMT_MMIO_SKIP_EN
  assign skip_d = wb_mem_access & (wb_mem_addr < MMIO_TOP);
`else
  logic unused_mem;
  assign unused_mem = &{1'b0, wb_mem_access, wb_mem_addr, MMIO_TOP};
  assign skip_d = 1'b0;
`endif
  assign halted = state != RUN;
  // next state: a retire always beats the watchdog on the same edge
  always_comb begin
    accept    = (state == RUN) & wb_valid;
    is_trap   = accept & (wb_inst[6:0] == TRAP_OPCODE);
    expire    = (state == RUN) & ~wb_valid & (wd == 32'(TIMEOUT - 1));
    wen_d     = wb_rd_wen & (wb_rd_waddr != 5'd0);
    state_nxt = is_trap ? TRAPPED : expire ? TIMED_OUT : state;
  end
  // state, commit registers, counters and sticky trap record
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= RUN;
      wd         <= '0;
      cmt_valid  <= 1'b0;
      cmt_pc     <= '0;
      cmt_inst   <= '0;
      cmt_wen    <= 1'b0;
      cmt_wdest  <= '0;
      cmt_wdata  <= '0;
      cmt_skip   <= 1'b0;
      trap_valid <= 1'b0;
      trap_code  <= '0;
      trap_pc    <= '0;
      cycle_cnt  <= '0;
      instr_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      cmt_valid <= accept;
      cmt_skip  <= accept & skip_d;
      if (state == RUN) begin
        cycle_cnt <= cycle_cnt + 64'd1;
        wd        <= accept ? '0 : wd + 32'd1;
      end
      if (accept) begin
        cmt_pc    <= wb_pc;
        cmt_inst  <= wb_inst;
        cmt_wen   <= wen_d;
        cmt_wdest <= {3'b0, wb_rd_waddr};
        cmt_wdata <= wen_d ? wb_rd_wdata : 64'd0;
        instr_cnt <= instr_cnt + 64'd1;
      end
      if (is_trap) begin
        trap_valid <= 1'b1;
        trap_code  <= wb_a0[7:0];
        trap_pc    <= wb_pc;
      end else if (expire) begin
        trap_valid <= 1'b1;
        trap_code  <= 8'hFF;
        trap_pc    <= cmt_pc;
      end
    end
  end
endmodule

// File: tb/tb_cmt_stage.sv
// tb_cmt_stage: randomized and directed checks of cmt_stage against a behavioural model
module tb_cmt_stage;
  localparam int TO = 8;
  logic        clock = 1'b0, reset = 1'b1;
  logic        wb_valid = 1'b0, wb_rd_wen = 1'b0, wb_mem_access = 1'b0;
  logic [63:0] wb_pc = '0, wb_rd_wdata = '0, wb_a0 = '0, wb_mem_addr = '0;
  logic [31:0] wb_inst = '0;
  logic [4:0]  wb_rd_waddr = '0;
  logic        cmt_valid, cmt_wen, cmt_skip, trap_valid, halted;
  logic [63:0] cmt_pc, cmt_wdata, trap_pc, cycle_cnt, instr_cnt;
  logic [31:0] cmt_inst;
  logic [7:0]  cmt_wdest, trap_code;
  int checks = 0, passes = 0;
  cmt_stage #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_inst(wb_inst),
    .wb_rd_wen(wb_rd_wen), .wb_rd_waddr(wb_rd_waddr), .wb_rd_wdata(wb_rd_wdata), .wb_a0(wb_a0),
    .wb_mem_access(wb_mem_access), .wb_mem_addr(wb_mem_addr), .cmt_valid(cmt_valid),
    .cmt_pc(cmt_pc), .cmt_inst(cmt_inst), .cmt_wen(cmt_wen), .cmt_wdest(cmt_wdest),
    .cmt_wdata(cmt_wdata), .cmt_skip(cmt_skip), .trap_valid(trap_valid), .trap_code(trap_code),
    .trap_pc(trap_pc), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .halted(halted)
  );
  always #5 clock = ~clock;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) $display("FAIL %s actual=%h required=%h at %0t", n, a, e, $time);
    else passes++;
  endtask
  // behavioural model: what each output must hold after every edge
  logic        e_valid, e_wen, e_skip, e_tv, m_halt;
  logic [63:0] e_pc, e_wdata, e_tp, m_cyc, m_instr;
  logic [31:0] e_inst;
  logic [7:0]  e_wdest, e_tc;
  int idle;
  always @(posedge clock) begin
    if (reset) begin
      {e_valid, e_wen, e_skip, e_tv, m_halt} = '0;
      {e_pc, e_wdata, e_tp, m_cyc, m_instr} = '0;
      e_inst = '0; e_wdest = '0; e_tc = '0; idle = 0;
    end else if (!m_halt) begin
      m_cyc = m_cyc + 1;
      if (wb_valid) begin
        e_valid = 1; e_pc = wb_pc; e_inst = wb_inst;
        e_wen = wb_rd_wen && wb_rd_waddr != 0;
        e_wdest = {3'b0, wb_rd_waddr};
        e_wdata = e_wen ? wb_rd_wdata : 0;
`ifdef CMT_MMIO_SKIP_EN
        e_skip = wb_mem_access && wb_mem_addr < 64'h8000_0000;
`else
        e_skip = 0;
`endif
        m_instr = m_instr + 1; idle = 0;
        if (wb_inst[6:0] == 7'h6b) begin e_tv = 1; e_tc = wb_a0[7:0]; e_tp = wb_pc; m_halt = 1; end
      end else begin
        e_valid = 0; e_skip = 0; idle++;
        if (idle == TO) begin e_tv = 1; e_tc = 8'hFF; e_tp = e_pc; m_halt = 1; end
      end
    end else begin
      e_valid = 0; e_skip = 0;
    end
    #1;
    chk("cmt_valid", 64'(cmt_valid), 64'(e_valid));
    chk("cmt_pc", cmt_pc, e_pc);
    chk("cmt_inst", 64'(cmt_inst), 64'(e_inst));
    chk("cmt_wen", 64'(cmt_wen), 64'(e_wen));
    chk("cmt_wdest", 64'(cmt_wdest), 64'(e_wdest));
    chk("cmt_wdata", cmt_wdata, e_wdata);
    chk("cmt_skip", 64'(cmt_skip), 64'(e_skip));
    chk("trap_valid", 64'(trap_valid), 64'(e_tv));
    chk("trap_code", 64'(trap_code), 64'(e_tc));
    chk("trap_pc", trap_pc, e_tp);
    chk("cycle_cnt", cycle_cnt, m_cyc);
    chk("instr_cnt", instr_cnt, m_instr);
    chk("halted", 64'(halted), 64'(m_halt));
  end
  task automatic retire(input logic [63:0] pc, input logic [31:0] inst, input logic wen,
                        input logic [4:0] rd, input logic [63:0] data, input logic [63:0] a0,
                        input logic mem, input logic [63:0] addr);
    @(negedge clock);
    wb_valid = 1; wb_pc = pc; wb_inst = inst; wb_rd_wen = wen; wb_rd_waddr = rd;
    wb_rd_wdata = data; wb_a0 = a0; wb_mem_access = mem; wb_mem_addr = addr;
    @(posedge clock); #2;
  endtask
  task automatic idle_n(input int n);
    repeat (n) begin @(negedge clock); wb_valid = 0; @(posedge clock); #2; end
  endtask
  task automatic do_reset;
    @(negedge clock); reset = 1; wb_valid = 0;
    @(posedge clock); #2;
    @(negedge clock); reset = 0;
  endtask
  logic skip_lo;
  logic [31:0] inst;
  int p;
  initial begin
`ifdef CMT_MMIO_SKIP_EN
    skip_lo = 1;
`else
    skip_lo = 0;
`endif
    do_reset;
    chk("lit_reset_valid", 64'(cmt_valid), 0);
    chk("lit_reset_cycle", cycle_cnt, 0);
    chk("lit_reset_trap", 64'(trap_valid), 0);
    retire(64'h8000_0000, 32'h0050_0093, 1, 1, 5, 0, 0, 0);
    chk("lit_first_valid", 64'(cmt_valid), 1);
    chk("lit_first_pc", cmt_pc, 64'h8000_0000);
    chk("lit_first_wen", 64'(cmt_wen), 1);
    chk("lit_first_wdest", 64'(cmt_wdest), 1);
    chk("lit_first_wdata", cmt_wdata, 5);
    chk("lit_first_instr", instr_cnt, 1);
    retire(64'h8000_0004, 32'h0000_0013, 1, 0, 64'h1234, 0, 0, 0);
    chk("lit_x0_wen", 64'(cmt_wen), 0);
    chk("lit_x0_wdata", cmt_wdata, 0);
    for (int i = 0; i < 3; i++) retire(64'h8000_0008 + 4 * i, 32'h0010_0113, 1, 2, i, 0, 0, 0);
    idle_n(2);
    chk("lit_burst_instr", instr_cnt, 5);
    retire(64'h8000_0010, 32'h0000_006b, 0, 0, 0, 0, 0, 0);
    chk("lit_trap_valid", 64'(cmt_valid), 1);
    chk("lit_trap_tv", 64'(trap_valid), 1);
    chk("lit_trap_code", 64'(trap_code), 0);
    chk("lit_trap_pc", trap_pc, 64'h8000_0010);
    chk("lit_trap_halted", 64'(halted), 1);
    retire(64'h8000_0014, 32'h0050_0093, 1, 1, 7, 0, 0, 0);
    chk("lit_halt_valid", 64'(cmt_valid), 0);
    chk("lit_halt_instr", instr_cnt, 6);
    do_reset;
    chk("lit_rst_trap", 64'(trap_valid), 0);
    chk("lit_rst_halted", 64'(halted), 0);
    retire(64'h8000_0004, 32'h0050_0093, 1, 1, 5, 0, 0, 0);
    idle_n(TO - 1);
    chk("lit_wd_before", 64'(trap_valid), 0);
    idle_n(1);
    chk("lit_wd_tv", 64'(trap_valid), 1);
    chk("lit_wd_code", 64'(trap_code), 64'hFF);
    chk("lit_wd_pc", trap_pc, 64'h8000_0004);
    do_reset;
    retire(64'h8000_0004, 32'h0050_0093, 1, 1, 5, 0, 0, 0);
    idle_n(TO - 1);
    retire(64'h8000_0008, 32'h0050_0093, 1, 1, 6, 0, 0, 0);
    idle_n(3);
    chk("lit_wd_suppressed", 64'(trap_valid), 0);
    do_reset;
    retire(64'h8000_0000, 32'h0000_3023, 0, 0, 0, 0, 1, 64'h1000_0000);
    chk("lit_skip_mmio", 64'(cmt_skip), 64'(skip_lo));
    retire(64'h8000_0004, 32'h0000_3023, 0, 0, 0, 0, 1, 64'h8000_0100);
    chk("lit_skip_ram", 64'(cmt_skip), 0);
    p = 90;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      if (c % 40 == 0) p = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(10, 95);
      reset = $urandom_range(0, 999) < (m_halt ? 60 : 3);
      inst = $urandom;
      if ($urandom_range(0, 99) < 3) inst[6:0] = 7'h6b;
      else if (inst[6:0] == 7'h6b) inst[0] = ~inst[0];
      wb_valid = $urandom_range(0, 99) < p;
      wb_pc = {$urandom, $urandom}; wb_inst = inst;
      wb_rd_wen = $urandom; wb_rd_waddr = $urandom_range(0, 31);
      wb_rd_wdata = {$urandom, $urandom}; wb_a0 = {$urandom, $urandom};
      wb_mem_access = $urandom;
      wb_mem_addr = $urandom_range(0, 1) ? 64'(32'($urandom) >> 1) : 64'h8000_0000 + 64'($urandom_range(0, 255));
    end
    @(negedge clock); reset = 0; wb_valid = 0;
    @(posedge clock); #3;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
